// File: rtl/bus_pkg.sv
// ----------------------------------------------------------------------------
// bus_pkg: shared select-code constants, transfer FSM states and code check.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bus_pkg;

  localparam int SEL_W = 5;

  localparam logic [SEL_W-1:0] SEL_HI     = 5'd16;
  localparam logic [SEL_W-1:0] SEL_LO     = 5'd17;
  localparam logic [SEL_W-1:0] SEL_ZHI    = 5'd18;
  localparam logic [SEL_W-1:0] SEL_ZLO    = 5'd19;
  localparam logic [SEL_W-1:0] SEL_PC     = 5'd20;
  localparam logic [SEL_W-1:0] SEL_MDR    = 5'd21;
  localparam logic [SEL_W-1:0] SEL_IR     = 5'd22;
  localparam logic [SEL_W-1:0] SEL_INPORT = 5'd23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WRITE = 2'd2
  } xfer_state_t;

  function automatic logic sel_valid(input logic [SEL_W-1:0] code, input int num_gpr);
    sel_valid = (int'(code) < num_gpr) || ((code >= SEL_HI) && (code <= SEL_INPORT));
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpr_file.sv
// ----------------------------------------------------------------------------
// gpr_file: general-purpose registers, one write port, two read ports.
// Option macro: R0_ZERO_EN (R0 hard-wired to zero). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module gpr_file
  import bus_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_GPR = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [SEL_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [SEL_W-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [SEL_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

`ifdef R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  localparam int              AW      = $clog2(NUM_GPR);
  localparam logic [SEL_W-1:0] NUM_SEL = SEL_W'(NUM_GPR);

  logic [DATA_W-1:0] rf [NUM_GPR];

  for (genvar i = 0; i < NUM_GPR; i++) begin : g_reg
    if (R0_ZERO && (i == 0)) begin : g_zero
      assign rf[i] = '0;
    end else begin : g_flop
      logic [DATA_W-1:0] q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          q <= '0;
        else if (we && (waddr == SEL_W'(i)))
          q <= wdata;
      end
      assign rf[i] = q;
    end
  end

  // Codes at or above NUM_GPR belong to other registers or are invalid: read 0.
  assign rdata_a = (raddr_a < NUM_SEL) ? rf[raddr_a[AW-1:0]] : '0;
  assign rdata_b = (raddr_b < NUM_SEL) ? rf[raddr_b[AW-1:0]] : '0;

endmodule

`default_nettype wire

// File: rtl/bus_xfer_unit.sv
// ----------------------------------------------------------------------------
// bus_xfer_unit: register set, shared bus mux and two-cycle transfer engine.
// Option macro: R0_ZERO_EN (handled in gpr_file). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bus_xfer_unit
  import bus_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_GPR = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [SEL_W-1:0]  rd_sel,
  input  logic              xfer_valid,
  output logic              xfer_ready,
  input  logic [SEL_W-1:0]  xfer_src,
  input  logic [SEL_W-1:0]  xfer_dst,
  output logic              xfer_done,
  output logic              xfer_err,
  output logic              wr_drop,
  output logic [DATA_W-1:0] bus_out
);

  xfer_state_t       state;
  logic [SEL_W-1:0]  src_q;
  logic [SEL_W-1:0]  dst_q;
  logic              err_q;
  logic [DATA_W-1:0] bus_latch;

  logic              we;
  logic [SEL_W-1:0]  waddr;
  logic [DATA_W-1:0] wdata;

  logic [DATA_W-1:0] gpr_rd;
  logic [DATA_W-1:0] gpr_src;
  logic [DATA_W-1:0] spec_q [8];
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] src_val;

  // Host writes own the port in IDLE, the engine owns it in WRITE; never both.
  always_comb begin
    we    = 1'b0;
    waddr = wr_sel;
    wdata = wr_data;
    if (state == IDLE) begin
      we = wr_en;
    end else if (state == WRITE) begin
      we    = 1'b1;
      waddr = dst_q;
      wdata = bus_latch;
    end
  end

  gpr_file #(
    .DATA_W  (DATA_W),
    .NUM_GPR (NUM_GPR)
  ) u_gpr (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (rd_sel),
    .rdata_a (gpr_rd),
    .raddr_b (src_q),
    .rdata_b (gpr_src)
  );

  // Special registers occupy codes 16..23, i.e. the 5'b10xxx block.
  for (genvar j = 0; j < 8; j++) begin : g_spec
    logic [DATA_W-1:0] q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        q <= '0;
      else if (we && (waddr == {2'b10, 3'(j)}))
        q <= wdata;
    end
    assign spec_q[j] = q;
  end

  assign rd_val  = gpr_rd  | ((rd_sel[4:3] == 2'b10) ? spec_q[rd_sel[2:0]] : '0);
  assign src_val = gpr_src | ((src_q[4:3]  == 2'b10) ? spec_q[src_q[2:0]]  : '0);

  always_comb begin
    case (state)
      DRIVE:   bus_out = src_val;
      WRITE:   bus_out = bus_latch;
      default: bus_out = rd_val;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      err_q      <= 1'b0;
      bus_latch  <= '0;
      xfer_ready <= 1'b1;
      xfer_done  <= 1'b0;
      xfer_err   <= 1'b0;
      wr_drop    <= 1'b0;
    end else begin
      xfer_done <= 1'b0;
      xfer_err  <= 1'b0;
      wr_drop   <= wr_en && (state != IDLE);
      case (state)
        IDLE: begin
          if (xfer_valid) begin
            src_q      <= xfer_src;
            dst_q      <= xfer_dst;
            err_q      <= !sel_valid(xfer_src, NUM_GPR) || !sel_valid(xfer_dst, NUM_GPR);
            xfer_ready <= 1'b0;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          bus_latch <= src_val;
          xfer_done <= 1'b1;
          xfer_err  <= err_q;
          state     <= WRITE;
        end
        WRITE: begin
          xfer_ready <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_xfer_unit.sv
// ----------------------------------------------------------------------------
// tb_bus_xfer_unit: drives a 16-GPR and an 8-GPR instance with the same
// directed stimulus and checks both against a transaction-level model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bus_xfer_unit;

  localparam int DW = 32;

`ifdef R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic          xfer_valid = 1'b0;
  logic [4:0]    wr_sel = '0;
  logic [4:0]    rd_sel = '0;
  logic [4:0]    xfer_src = '0;
  logic [4:0]    xfer_dst = '0;
  logic [DW-1:0] wr_data = '0;

  logic          rdy  [2];
  logic          done [2];
  logic          err  [2];
  logic          drop [2];
  logic [DW-1:0] bus  [2];

  int total = 0;
  int bad = 0;
  bit running = 1'b0;

  always #5 clk = ~clk;

  bus_xfer_unit #(.DATA_W(DW), .NUM_GPR(16)) u16 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_sel(rd_sel), .xfer_valid(xfer_valid), .xfer_ready(rdy[0]),
    .xfer_src(xfer_src), .xfer_dst(xfer_dst), .xfer_done(done[0]),
    .xfer_err(err[0]), .wr_drop(drop[0]), .bus_out(bus[0])
  );

  bus_xfer_unit #(.DATA_W(DW), .NUM_GPR(8)) u8 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_sel(rd_sel), .xfer_valid(xfer_valid), .xfer_ready(rdy[1]),
    .xfer_src(xfer_src), .xfer_dst(xfer_dst), .xfer_done(done[1]),
    .xfer_err(err[1]), .wr_drop(drop[1]), .bus_out(bus[1])
  );

  // Model: register contents plus the one transfer in flight (value, target,
  // error flag, and how many edges have passed since it was accepted).
  logic [DW-1:0] mreg [2][32];
  int            cnt  [2];
  logic [4:0]    mdst [2];
  logic [DW-1:0] mval [2];
  logic          merr [2];
  logic          mdrop[2];

  function automatic int ngpr(int k);
    return (k == 0) ? 16 : 8;
  endfunction

  function automatic bit mvalid(int k, logic [4:0] c);
    return (int'(c) < ngpr(k)) || ((c >= 5'd16) && (c <= 5'd23));
  endfunction

  function automatic logic [DW-1:0] mrd(int k, logic [4:0] c);
    if (!mvalid(k, c)) return '0;
    if (R0Z && (c == 5'd0)) return '0;
    return mreg[k][c];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 32; c++) mreg[k][c] = '0;
      cnt[k] = 0; mdst[k] = '0; mval[k] = '0; merr[k] = 1'b0; mdrop[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      model_clear();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      mdrop[k] = wr_en && (cnt[k] != 0);
      if (cnt[k] == 0) begin
        if (wr_en && mvalid(k, wr_sel)) mreg[k][wr_sel] = wr_data;
        if (xfer_valid) begin
          mval[k] = mrd(k, xfer_src);
          mdst[k] = xfer_dst;
          merr[k] = !mvalid(k, xfer_src) || !mvalid(k, xfer_dst);
          cnt[k]  = 1;
        end
      end else if (cnt[k] == 1) begin
        cnt[k] = 2;
      end else begin
        if (mvalid(k, mdst[k])) mreg[k][mdst[k]] = mval[k];
        cnt[k] = 0;
      end
    end
  endtask

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after each rising edge; the model steps on the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (running) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("ready_g%0d", ngpr(k)), 32'(rdy[k]),  32'(cnt[k] == 0));
          chk($sformatf("done_g%0d",  ngpr(k)), 32'(done[k]), 32'(cnt[k] == 2));
          chk($sformatf("err_g%0d",   ngpr(k)), 32'(err[k]),  32'((cnt[k] == 2) && merr[k]));
          chk($sformatf("drop_g%0d",  ngpr(k)), 32'(drop[k]), 32'(mdrop[k]));
          chk($sformatf("bus_g%0d",   ngpr(k)), bus[k],
              (cnt[k] == 0) ? mrd(k, rd_sel) : mval[k]);
        end
      end
    end
  end

  task automatic hwr(logic [4:0] sel, logic [DW-1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic xfer(logic [4:0] s, logic [4:0] d);
    xfer_valid = 1'b1; xfer_src = s; xfer_dst = d;
    step();
    xfer_valid = 1'b0;
  endtask

  initial begin
    model_clear();
    #1 reset = 1'b1;
    model_clear();
    running = 1'b1;
    step(); step();
    chk("rst_ready", 32'(rdy[0]), 32'd1);
    chk("rst_bus", bus[0], 32'h0);
    reset = 1'b0;

    hwr(5'd0, 32'hDEADBEEF);
    hwr(5'd20, 32'h12345678);
    hwr(5'd22, 32'hCAFEBABE);
    hwr(5'd24, 32'h0BADF00D);
    rd_sel = 5'd0;  #1 chk("rd_r0", bus[0], R0Z ? 32'h0 : 32'hDEADBEEF);
    rd_sel = 5'd20; #1 chk("rd_pc", bus[0], 32'h12345678);
    rd_sel = 5'd22; #1 chk("rd_ir", bus[1], 32'hCAFEBABE);
    rd_sel = 5'd24; #1 chk("rd_inval", bus[0], 32'h0);

    rd_sel = 5'd1;
    xfer(5'd20, 5'd1);
    #2 chk("drive_ready", 32'(rdy[0]), 32'd0);
    chk("drive_bus", bus[0], 32'h12345678);
    step();
    #2 chk("write_done", 32'(done[0]), 32'd1);
    chk("write_ready", 32'(rdy[0]), 32'd0);
    step();
    #2 chk("r1_after", bus[0], 32'h12345678);
    chk("ready_back", 32'(rdy[0]), 32'd1);

    wr_en = 1'b1; wr_sel = 5'd2; wr_data = 32'hFACECAFE;
    xfer(5'd2, 5'd3);
    wr_en = 1'b0;
    step(); step();
    rd_sel = 5'd3; #2 chk("r3_fwd", bus[0], 32'hFACECAFE);

    xfer(5'd20, 5'd6);
    wr_en = 1'b1; wr_sel = 5'd4; wr_data = 32'h11111111;
    step();
    #2 chk("wr_drop", 32'(drop[0]), 32'd1);
    wr_en = 1'b0;
    step();
    rd_sel = 5'd4; #2 chk("r4_kept", bus[0], 32'h0);

    rd_sel = 5'd9;
    xfer(5'd9, 5'd1);
    step();
    #2 chk("src9_err_g8", 32'(err[1]), 32'd1);
    chk("src9_done_g8", 32'(done[1]), 32'd1);
    chk("src9_ok_g16", 32'(err[0]), 32'd0);
    step();
    #2 chk("rd9_g8", bus[1], 32'h0);
    xfer(5'd20, 5'd25);
    step();
    #2 chk("dst25_err", 32'(err[0]), 32'd1);
    step();

    xfer(5'd22, 5'd22);
    step(); step();
    rd_sel = 5'd22; #2 chk("self_xfer", bus[1], 32'hCAFEBABE);

    rd_sel = 5'd5;
    xfer(5'd20, 5'd5);
    reset = 1'b1;
    model_clear();
    #2 chk("abort_ready", 32'(rdy[0]), 32'd1);
    chk("abort_done", 32'(done[0]), 32'd0);
    step();
    reset = 1'b0;
    #2 chk("abort_r5", bus[0], 32'h0);
    step(); step();
    rd_sel = 5'd20; #2 chk("pc_cleared", bus[0], 32'h0);
    step();

    running = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
